// File: rtl/spi_note_sender.sv
// Queues MIDI note events in a small FIFO and serialises each as a 24-bit
// SPI mode-0 frame (MSB first), followed by a fixed idle gap.
module spi_note_sender #(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8,
   parameter int DEPTH      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_note_status,
   input  logic [7:0] in_voice_index,
   input  logic [6:0] in_midi_note,
   input  logic [6:0] in_velocity,
   output logic       SPI_sclk,
   output logic       SPI_mosi,
   output logic       busy,
   output logic       frame_done,
   output logic       overflow
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   typedef struct packed {
      logic       note_status;
      logic [6:0] midi_note;
      logic [7:0] voice_index;
      logic [6:0] velocity;
   } note_evt_t;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

   note_evt_t     fifo_mem [DEPTH];
   note_evt_t     evt_in, head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, empty, push, pop;
   logic [23:0]   frame;

   state_t        state;
   logic [22:0]   shreg;
   logic [4:0]    bit_cnt;
   logic [7:0]    div_cnt;
   logic          phase_hi;
   logic [7:0]    gap_cnt;

   assign evt_in   = '{note_status: in_note_status, midi_note: in_midi_note,
                       voice_index: in_voice_index, velocity: in_velocity};
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign in_ready = !full;
   // Readiness ignores a same-cycle pop, so a push into a full FIFO is always dropped.
   assign push     = in_valid && !full;
   assign pop      = (state == LOAD);
   assign busy     = (state != IDLE) || !empty;
   assign head     = fifo_mem[rd_ptr];
   assign frame    = {head.note_status, head.midi_note, head.voice_index, 1'b0, head.velocity};

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= evt_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (in_valid && !in_ready) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         SPI_sclk   <= 1'b0;
         SPI_mosi   <= 1'b0;
         frame_done <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         phase_hi   <= 1'b0;
         gap_cnt    <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               SPI_sclk <= 1'b0;
               SPI_mosi <= 1'b0;
               if (!empty) state <= LOAD;
            end
            LOAD: begin
               SPI_mosi <= frame[23];
               shreg    <= frame[22:0];
               bit_cnt  <= '0;
               div_cnt  <= '0;
               phase_hi <= 1'b0;
               state    <= SHIFT;
            end
            SHIFT: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + 8'd1;
               end else begin
                  div_cnt <= '0;
                  if (!phase_hi) begin
                     phase_hi <= 1'b1;
                     SPI_sclk <= 1'b1;
                  end else begin
                     // Falling edge is the bit boundary: mosi only moves here.
                     phase_hi <= 1'b0;
                     SPI_sclk <= 1'b0;
                     if (bit_cnt == 5'd23) begin
                        SPI_mosi   <= 1'b0;
                        gap_cnt    <= '0;
                        frame_done <= (GAP_LAST == 8'd0);
                        state      <= GAP;
                     end else begin
                        bit_cnt  <= bit_cnt + 5'd1;
                        SPI_mosi <= shreg[22];
                        shreg    <= {shreg[21:0], 1'b0};
                     end
                  end
               end
            end
            GAP: begin
               // frame_done is registered one cycle early so it lands on the last gap cycle.
               if (gap_cnt == GAP_LAST) begin
                  state <= IDLE;
               end else begin
                  gap_cnt    <= gap_cnt + 8'd1;
                  frame_done <= (gap_cnt + 8'd1 == GAP_LAST);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
